// File: rtl/switch_debounce_8_pkg.sv
// switch_debounce_8_pkg: shared debounce constants and counter width helper
package switch_debounce_8_pkg;
   localparam int DEBOUNCE_10MS_100MHZ = 1000000;
   localparam int SIM_DEBOUNCE = 4;
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/switch_debounce_8_bit.sv
// debounce_bit: one switch channel, 2-flop synchroniser plus stable-time filter
module debounce_bit
   import switch_debounce_8_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic stable,
   output logic update
);
   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   logic s1, s2;
   logic [CNT_W-1:0] cnt;
   assign update = (s2 != stable) && (cnt == LAST);
   // any return to the stable level restarts the full interval
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         s1     <= raw;
         s2     <= s1;
         cnt    <= (s2 == stable || update) ? '0 : cnt + 1'b1;
         stable <= update ? s2 : stable;
      end
   end
endmodule

// File: rtl/switch_debounce_8.sv
// switch_debounce_8: debounced switch bank with change and rising-edge strobes
module switch_debounce_8
   import switch_debounce_8_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic             sw_changed,
   output logic [WIDTH-1:0] sw_rise
);
   logic [WIDTH-1:0] update;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
         .clk    (clk),
         .rst    (rst),
         .raw    (sw_raw[i]),
         .stable (sw_stable[i]),
         .update (update[i])
      );
   end
   // strobes share the edge of the stable update; old stable 0 means a rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_changed <= 1'b0;
         sw_rise    <= '0;
      end else begin
         sw_changed <= |update;
         sw_rise    <= update & ~sw_stable;
      end
   end
endmodule

// File: tb/tb_switch_debounce_8.sv
// tb_switch_debounce_8: directed checks of the debouncer with a 4-cycle filter
module tb_switch_debounce_8;
   import switch_debounce_8_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sw_raw = 8'hA5;
   logic [7:0] sw_stable;
   logic       sw_changed;
   logic [7:0] sw_rise;
   int checks = 0;
   int errors = 0;

   switch_debounce_8 #(.WIDTH(8), .DEBOUNCE_CYCLES(SIM_DEBOUNCE)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw_raw     (sw_raw),
      .sw_stable  (sw_stable),
      .sw_changed (sw_changed),
      .sw_rise    (sw_rise)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] st, input logic ch, input logic [7:0] ri);
      chk({tag, "_stable"}, sw_stable, st);
      chk({tag, "_changed"}, {7'd0, sw_changed}, {7'd0, ch});
      chk({tag, "_rise"}, sw_rise, ri);
   endtask

   function automatic logic [7:0] enc(input logic [7:0] d);
      logic [7:0] r = 8'd0;
      for (int k = 0; k < 8; k++) if (d[k]) r = 8'(k);
      return r;
   endfunction

   initial begin
      // 1: power-up with switches held through reset
      repeat (3) step();
      chk_out("reset", 8'h00, 1'b0, 8'h00);
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk_out("pwrup_wait", 8'h00, 1'b0, 8'h00);
      end
      step();
      chk_out("pwrup_edge6", 8'hA5, 1'b1, 8'hA5);
      step();
      chk_out("pwrup_after", 8'hA5, 1'b0, 8'h00);
      sw_raw = 8'h00;
      repeat (5) step();
      chk("fall_wait", sw_stable, 8'hA5);
      step();
      chk_out("fall_edge6", 8'h00, 1'b1, 8'h00);
      repeat (2) step();
      // 2: 3-cycle glitch on bit 7
      sw_raw = 8'h80;
      repeat (3) step();
      sw_raw = 8'h00;
      for (int k = 0; k < 3; k++) begin
         chk_out("glitch", 8'h00, 1'b0, 8'h00);
         step();
      end
      for (int k = 0; k < 6; k++) begin
         step();
         chk_out("glitch_late", 8'h00, 1'b0, 8'h00);
      end
      // 3: bounce on bit 0, two cycles per level, ending high
      for (int k = 0; k < 10; k++) begin
         sw_raw = (k % 4 < 2) ? 8'h01 : 8'h00;
         step();
         chk_out("bounce", 8'h00, 1'b0, 8'h00);
      end
      sw_raw = 8'h01;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_out("bounce_settle", 8'h00, 1'b0, 8'h00);
      end
      step();
      chk_out("bounce_edge6", 8'h01, 1'b1, 8'h01);
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out("bounce_hold", 8'h01, 1'b0, 8'h00);
      end
      // 4: simultaneous fall of bit 3 and rise of bit 6
      sw_raw = 8'h08;
      repeat (5) step();
      chk("pre08_wait", sw_stable, 8'h01);
      step();
      chk_out("to08", 8'h08, 1'b1, 8'h08);
      repeat (2) step();
      sw_raw = 8'h40;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_out("simul_wait", 8'h08, 1'b0, 8'h00);
      end
      step();
      chk_out("simul_edge6", 8'h40, 1'b1, 8'h40);
      step();
      chk_out("simul_after", 8'h40, 1'b0, 8'h00);
      // 5: reset mid-count, then asynchronous clear while strobes are high
      sw_raw = 8'h00;
      repeat (8) step();
      chk("pre_rst", sw_stable, 8'h00);
      sw_raw = 8'hFF;
      repeat (3) step();
      #2 rst = 1'b1;
      #1 chk_out("rst_mid", 8'h00, 1'b0, 8'h00);
      step();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk_out("rst_restart", 8'h00, 1'b0, 8'h00);
      end
      step();
      chk_out("rst_edge6", 8'hFF, 1'b1, 8'hFF);
      #2 rst = 1'b1;
      #1 chk_out("rst_async", 8'h00, 1'b0, 8'h00);
      step();
      // 6: feed the encoder, no intermediate code
      sw_raw = 8'b0001_0110;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("enc_wait", enc(sw_stable), 8'd0);
      end
      step();
      chk("enc_edge6", enc(sw_stable), 8'd4);
      chk("enc_stable", sw_stable, 8'h16);
      step();
      chk("enc_hold", enc(sw_stable), 8'd4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
